fsm5_result_monitor: RTL and testbench

- Sits directly downstream of FSM5, the pattern-search FSM that scans data_in for 4'b1011 over up to 100 cycles.
- Passively watches FSM5's start/AVAIL/DONE/flag handshake and checks each job's DONE protocol.
- Turns every completed job into a result record (outcome code + latency) and buffers the records in a small ready/valid FIFO for a downstream consumer.
- Keeps saturating statistics counters for found / not-found / error outcomes.

---
 rtl/fsm5_mon_pkg.sv | 40 ++++
 rtl/fsm5_result_monitor_if.sv | 27 ++
 rtl/fsm5_result_fifo.sv | 68 ++++++
 rtl/fsm5_result_monitor.sv | 182 ++++++++++++++++++
 tb/tb_fsm5_result_monitor.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm5_mon_pkg.sv
// Shared types and defaults for the FSM5 result monitor.
//   state_t  : monitor FSM states
//   code_t   : outcome code stored in each result record
//   result_t : result record {code, latency} at the default latency width
package fsm5_mon_pkg;

    localparam int unsigned LAT_W_DEF   = 7;
    localparam int unsigned LAT_MAX_DEF = 104;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE1 = 2'b10,
        DONE2 = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        NOT_FOUND = 2'b00,
        FOUND     = 2'b01,
        PROTO_ERR = 2'b10,
        TIMEOUT   = 2'b11
    } code_t;

    typedef struct packed {
        code_t                code;
        logic [LAT_W_DEF-1:0] lat;
    } result_t;

    // Map a captured FSM5 flag to the outcome of a cleanly finished job.
    function automatic code_t flag_to_code(input logic [1:0] flag);
        code_t code;
        case (flag)
            2'b00:   code = NOT_FOUND;
            2'b01:   code = FOUND;
            default: code = PROTO_ERR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fsm5_result_monitor_if.sv
// Bus between FSM5 / the record consumer and the result monitor.
//   start, avail, done, flag : FSM5 handshake, observed only
//   out_valid, out_ready     : ready/valid handshake for result records
//   out_data                 : record {code[1:0], latency[LAT_W-1:0]}
// slave  : the monitor side
// master : the environment side (FSM5 taps + record consumer)
interface fsm5_result_monitor_if #(
    parameter int unsigned LAT_W = 7
);
    logic             start;
    logic             avail;
    logic             done;
    logic [1:0]       flag;
    logic             out_valid;
    logic             out_ready;
    logic [LAT_W+1:0] out_data;

    modport slave (
        input  start, avail, done, flag, out_ready,
        output out_valid, out_data
    );

    modport master (
        output start, avail, done, flag, out_ready,
        input  out_valid, out_data
    );
endinterface

// File: rtl/fsm5_result_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is read
// straight from the storage registers (first-word fall-through).
//   i_push/i_data : write request; ignored when full unless popping
//   i_pop         : read request; ignored when empty
//   o_valid       : head holds an entry (registered)
//   o_data        : head entry
//   o_full_c      : combinational full flag
module fsm5_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_valid;

    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic [PW-1:0]    w_wr_nxt;
    logic [PW-1:0]    w_rd_nxt;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign w_wr_nxt  = w_do_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
    assign w_rd_nxt  = w_do_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;

    // Storage and pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
            end
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_valid  <= (w_wr_nxt != w_rd_nxt);
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full_c = w_full;

endmodule

// File: rtl/fsm5_result_monitor.sv
// Passive protocol monitor for FSM5. Tracks each job from accept to the end
// of its two-cycle DONE pulse, turns it into a {code, latency} record,
// queues records in a small FIFO and keeps saturating outcome statistics.
//   clk, reset_n      : clock, asynchronous active-low reset
//   bus (slave)       : FSM5 taps and the record ready/valid stream
//   i_clr_stats       : synchronous clear of counters and overflow flag
//   o_cnt_found       : FOUND jobs
//   o_cnt_not_found   : NOT_FOUND jobs
//   o_cnt_err         : PROTO_ERR + TIMEOUT jobs + stray DONE rising edges
//   o_overflow        : sticky, a record was dropped on a full FIFO
module fsm5_result_monitor
    import fsm5_mon_pkg::*;
#(
    parameter int unsigned LAT_W   = LAT_W_DEF,
    parameter int unsigned LAT_MAX = LAT_MAX_DEF,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    fsm5_result_monitor_if.slave    bus,
    input  logic                    i_clr_stats,
    output logic [CNT_W-1:0]        o_cnt_found,
    output logic [CNT_W-1:0]        o_cnt_not_found,
    output logic [CNT_W-1:0]        o_cnt_err,
    output logic                    o_overflow
);
    localparam int unsigned REC_W = LAT_W + 2;

    state_t           r_state;
    logic [LAT_W-1:0] r_lat;
    logic [1:0]       r_flag;
    logic             r_done_q;
    logic [CNT_W-1:0] r_cnt_found;
    logic [CNT_W-1:0] r_cnt_not_found;
    logic [CNT_W-1:0] r_cnt_err;
    logic             r_overflow;

    logic             w_accept;
    logic             w_stray;
    logic             w_push;
    code_t            w_code;
    logic             w_pop;
    logic             w_full;
    logic             w_fifo_valid;
    logic [REC_W-1:0] w_fifo_data;

    assign w_accept = (r_state == IDLE) & bus.start & bus.avail;
    // An accept in the same cycle masks a DONE edge.
    assign w_stray  = (r_state == IDLE) & ~w_accept & bus.done & ~r_done_q;
    assign w_pop    = w_fifo_valid & bus.out_ready;

    // Job-exit decode: a record is pushed in the cycle the FSM returns to IDLE.
    always_comb begin
        w_push = 1'b0;
        w_code = PROTO_ERR;
        case (r_state)
            BUSY: begin
                if (!bus.done) begin
                    if (bus.avail) begin
                        w_push = 1'b1;
                        w_code = PROTO_ERR;
                    end else if (r_lat == LAT_W'(LAT_MAX)) begin
                        w_push = 1'b1;
                        w_code = TIMEOUT;
                    end
                end
            end
            DONE1: begin
                if (!(bus.done && (bus.flag == r_flag))) begin
                    w_push = 1'b1;
                    w_code = PROTO_ERR;
                end
            end
            DONE2: begin
                w_push = 1'b1;
                w_code = bus.done ? PROTO_ERR : flag_to_code(r_flag);
            end
            default: begin
                w_push = 1'b0;
                w_code = PROTO_ERR;
            end
        endcase
    end

    // Job-tracking FSM with latency counter and captured flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_lat    <= '0;
            r_flag   <= 2'b00;
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= bus.done;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= BUSY;
                        r_lat   <= LAT_W'(1);
                    end
                end
                BUSY: begin
                    if (bus.done) begin
                        r_flag  <= bus.flag;
                        r_state <= DONE1;
                    end else if (w_push) begin
                        r_state <= IDLE;
                    end else if (~&r_lat) begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                DONE1: begin
                    r_state <= w_push ? IDLE : DONE2;
                end
                DONE2: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Saturating statistics and sticky overflow; clear beats any increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_found     <= '0;
            r_cnt_not_found <= '0;
            r_cnt_err       <= '0;
            r_overflow      <= 1'b0;
        end else if (i_clr_stats) begin
            r_cnt_found     <= '0;
            r_cnt_not_found <= '0;
            r_cnt_err       <= '0;
            r_overflow      <= 1'b0;
        end else begin
            if (w_push) begin
                case (w_code)
                    FOUND: begin
                        if (~&r_cnt_found) r_cnt_found <= r_cnt_found + CNT_W'(1);
                    end
                    NOT_FOUND: begin
                        if (~&r_cnt_not_found) r_cnt_not_found <= r_cnt_not_found + CNT_W'(1);
                    end
                    default: begin
                        if (~&r_cnt_err) r_cnt_err <= r_cnt_err + CNT_W'(1);
                    end
                endcase
            end
            // Stray DONE only occurs in IDLE, so it never collides with a push.
            if (w_stray && (~&r_cnt_err)) begin
                r_cnt_err <= r_cnt_err + CNT_W'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    fsm5_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_push   (w_push),
        .i_data   ({w_code, r_lat}),
        .i_pop    (bus.out_ready),
        .o_valid  (w_fifo_valid),
        .o_data   (w_fifo_data),
        .o_full_c (w_full)
    );

    assign bus.out_valid   = w_fifo_valid;
    assign bus.out_data    = w_fifo_data;
    assign o_cnt_found     = r_cnt_found;
    assign o_cnt_not_found = r_cnt_not_found;
    assign o_cnt_err       = r_cnt_err;
    assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_fsm5_result_monitor.sv
// Directed bench for fsm5_result_monitor: a table of complete jobs plus
// hand sequences for timeout, AVAIL error, stray DONE, overflow, clear and
// asynchronous reset. A second instance with 2-bit counters checks saturation.
module tb_fsm5_result_monitor;
    import fsm5_mon_pkg::*;

    localparam int unsigned LW = 7;

    logic clk = 1'b0;
    logic reset_n;
    logic clr_stats;

    logic [15:0] cnt_found, cnt_nf, cnt_err;
    logic        ovf;
    logic [1:0]  s_found, s_nf, s_err;
    logic        s_ovf;

    fsm5_result_monitor_if #(.LAT_W(LW)) bus ();
    fsm5_result_monitor_if #(.LAT_W(LW)) bus_s ();

    assign bus_s.start     = bus.start;
    assign bus_s.avail     = bus.avail;
    assign bus_s.done      = bus.done;
    assign bus_s.flag      = bus.flag;
    assign bus_s.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    fsm5_result_monitor #(.LAT_W(LW), .LAT_MAX(104), .DEPTH(4), .CNT_W(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .i_clr_stats     (clr_stats),
        .o_cnt_found     (cnt_found),
        .o_cnt_not_found (cnt_nf),
        .o_cnt_err       (cnt_err),
        .o_overflow      (ovf)
    );

    fsm5_result_monitor #(.LAT_W(LW), .LAT_MAX(104), .DEPTH(4), .CNT_W(2)) dut_s (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus_s),
        .i_clr_stats     (clr_stats),
        .o_cnt_found     (s_found),
        .o_cnt_not_found (s_nf),
        .o_cnt_err       (s_err),
        .o_overflow      (s_ovf)
    );

    typedef struct {
        int          lat;
        int          ndone;
        logic [1:0]  f1;
        logic [1:0]  f2;
        code_t       code;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;
    int   e_found = 0, e_nf = 0, e_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        bus.start = 1'b1;
        bus.avail = 1'b1;
        step();
        bus.start = 1'b0;
        bus.avail = 1'b0;
    endtask

    // Accept, first DONE sample at latency 'lat', DONE high for nd edges.
    task automatic run_job(input int lat, input int nd, input logic [1:0] f1, input logic [1:0] f2);
        accept();
        repeat (lat - 1) step();
        for (int i = 0; i < nd; i++) begin
            bus.done = 1'b1;
            bus.flag = (i == 0) ? f1 : f2;
            step();
        end
        bus.done = 1'b0;
        bus.flag = 2'b00;
        step();
    endtask

    task automatic chk_head(input string nm, input code_t c, input int lat);
        result_t r;
        r.code = c;
        r.lat  = LW'(lat);
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_data"}, 32'(bus.out_data), 32'(r));
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, "_found"}, 32'(cnt_found), 32'(e_found));
        chk({nm, "_nf"}, 32'(cnt_nf), 32'(e_nf));
        chk({nm, "_err"}, 32'(cnt_err), 32'(e_err));
        chk({nm, "_s_found"}, 32'(s_found), 32'(sat3(e_found)));
        chk({nm, "_s_nf"}, 32'(s_nf), 32'(sat3(e_nf)));
        chk({nm, "_s_err"}, 32'(s_err), 32'(sat3(e_err)));
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{5,   2, 2'b01, 2'b01, FOUND};
        vecs[1] = '{100, 2, 2'b00, 2'b00, NOT_FOUND};
        vecs[2] = '{3,   1, 2'b01, 2'b01, PROTO_ERR};
        vecs[3] = '{7,   3, 2'b01, 2'b01, PROTO_ERR};
        vecs[4] = '{4,   2, 2'b01, 2'b00, PROTO_ERR};
        vecs[5] = '{9,   2, 2'b10, 2'b10, PROTO_ERR};
        vecs[6] = '{1,   2, 2'b01, 2'b01, FOUND};
        vecs[7] = '{103, 2, 2'b00, 2'b00, NOT_FOUND};

        bus.start = 1'b0; bus.avail = 1'b0; bus.done = 1'b0; bus.flag = 2'b00;
        bus.out_ready = 1'b0;
        clr_stats = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk_counts("rst");
        reset_n = 1'b1;
        step();

        // Table of complete jobs, one record each.
        for (int v = 0; v < 8; v++) begin
            chk($sformatf("v%0d_pre_valid", v), 32'(bus.out_valid), 32'd0);
            run_job(vecs[v].lat, vecs[v].ndone, vecs[v].f1, vecs[v].f2);
            case (vecs[v].code)
                FOUND:     e_found++;
                NOT_FOUND: e_nf++;
                default:   e_err++;
            endcase
            chk_head($sformatf("v%0d", v), vecs[v].code, vecs[v].lat);
            chk_counts($sformatf("v%0d", v));
            pop();
            chk($sformatf("v%0d_post_valid", v), 32'(bus.out_valid), 32'd0);
        end

        // Timeout at LAT_MAX, then a normal job is still accepted.
        accept();
        repeat (103) step();
        chk("to_before", 32'(bus.out_valid), 32'd0);
        step();
        e_err++;
        chk_head("to", TIMEOUT, 104);
        chk_counts("to");
        pop();
        run_job(2, 2, 2'b01, 2'b01);
        e_found++;
        chk_head("after_to", FOUND, 2);
        pop();

        // AVAIL reasserted while BUSY.
        accept();
        step();
        step();
        bus.avail = 1'b1;
        step();
        bus.avail = 1'b0;
        e_err++;
        chk_head("avail_err", PROTO_ERR, 3);
        chk_counts("avail_err");
        pop();

        // Stray DONE in IDLE: counted once, no record.
        bus.done = 1'b1;
        step();
        step();
        bus.done = 1'b0;
        step();
        e_err++;
        chk("stray_valid", 32'(bus.out_valid), 32'd0);
        chk_counts("stray");

        // Accept with DONE already high: accept wins, job ends FOUND at latency 1.
        bus.start = 1'b1; bus.avail = 1'b1; bus.done = 1'b1; bus.flag = 2'b01;
        step();
        bus.start = 1'b0; bus.avail = 1'b0;
        step();
        step();
        bus.done = 1'b0; bus.flag = 2'b00;
        step();
        e_found++;
        chk_head("prec", FOUND, 1);
        chk_counts("prec");
        pop();

        // Overflow: five jobs with no consumer, fifth dropped.
        for (int k = 0; k < 5; k++) begin
            run_job(2 + k, 2, 2'b01, 2'b01);
            e_found++;
        end
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_set_s", 32'(s_ovf), 32'd1);
        chk_counts("ovf");
        for (int k = 0; k < 4; k++) begin
            chk_head($sformatf("ovf_pop%0d", k), FOUND, 2 + k);
            pop();
        end
        chk("ovf_empty", 32'(bus.out_valid), 32'd0);

        // Statistics clear.
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        e_found = 0; e_nf = 0; e_err = 0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk_counts("clr");

        // Saturate the small counters, fill the FIFO, then reset mid-BUSY.
        for (int k = 0; k < 5; k++) begin
            run_job(1, 2, 2'b01, 2'b01);
            e_found++;
        end
        chk_counts("sat");
        chk("sat_ovf", 32'(ovf), 32'd1);
        accept();
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        e_found = 0; e_nf = 0; e_err = 0;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data", 32'(bus.out_data), 32'd0);
        chk("arst_valid_s", 32'(bus_s.out_valid), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_ovf_s", 32'(s_ovf), 32'd0);
        chk_counts("arst");
        step();
        reset_n = 1'b1;
        repeat (4) step();
        chk("arst_norec", 32'(bus.out_valid), 32'd0);
        chk_counts("arst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
